// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding, requester IDs and default limits for the memory port arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, D_BUSY = 2'd1, I_BUSY = 2'd2} state_e;
  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;
  localparam int DEF_MAX_D_STREAK = 4;
  localparam int DEF_TIMEOUT = 255;
endpackage

// File: rtl/mem_arb_timer.sv
// mem_arb_timer: loadable up-counter that stops at TIMEOUT and flags terminal count
module mem_arb_timer #(
  parameter int TIMEOUT = 255,
  localparam int W = $clog2(TIMEOUT + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld_i,
  input  logic [W-1:0] ld_val_i,
  input  logic         en_i,
  output logic         tc_o
);
  logic [W-1:0] cnt_q, cnt_d;
  assign tc_o = cnt_q == W'(TIMEOUT);
  always_comb cnt_d = ld_i ? ld_val_i : (en_i && !tc_o) ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one variable-latency memory port between fetch and data requesters,
// data-first with a streak limit so fetch is never starved, and a per-transaction timeout
module mem_port_arbiter import mem_arb_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MAX_D_STREAK = DEF_MAX_D_STREAK,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              bus_err,
  output logic              mem_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  state_e state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic mem_valid_q, mem_valid_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d, i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic i_done_q, i_done_d, d_done_q, d_done_d, bus_err_q, bus_err_d;
  logic i_m, d_m, sat, idle, busy, grant_d, grant_i, tmo, fin_ok, fin_to, fin, owner;
  // a requester is masked in its own done cycle so a held req is not re-served
  assign i_m     = i_req & ~i_done_q;
  assign d_m     = d_req & ~d_done_q;
  assign sat     = streak_q == SW'(MAX_D_STREAK);
  assign idle    = state_q == IDLE;
  assign busy    = !idle;
  assign grant_d = idle & d_m & ~(i_m & sat);
  assign grant_i = idle & ~grant_d & i_m;
  assign fin_ok  = busy & mem_ready;
  assign fin_to  = busy & ~mem_ready & tmo;
  assign fin     = fin_ok | fin_to;
  assign owner   = state_q == D_BUSY ? REQ_D : REQ_I;
  mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk(clk), .rst(rst), .ld_i(grant_d | grant_i), .ld_val_i(TW'(0)), .en_i(busy), .tc_o(tmo)
  );
  always_comb begin
    state_d     = grant_d ? D_BUSY : grant_i ? I_BUSY : fin ? IDLE : state_q;
    streak_d    = grant_d ? (i_m ? (sat ? streak_q : streak_q + SW'(1)) : '0) : grant_i ? '0 : streak_q;
    mem_valid_d = (grant_d | grant_i) ? 1'b1 : fin ? 1'b0 : mem_valid_q;
    mem_we_d    = grant_d ? d_we : grant_i ? 1'b0 : mem_we_q;
    mem_addr_d  = grant_d ? d_addr : grant_i ? i_addr : mem_addr_q;
    mem_wdata_d = grant_d ? d_wdata : grant_i ? '0 : mem_wdata_q;
    i_done_d    = fin & (owner == REQ_I);
    d_done_d    = fin & (owner == REQ_D);
    bus_err_d   = fin_to;
    i_rdata_d   = (fin_ok && owner == REQ_I) ? mem_rdata : i_rdata_q;
    d_rdata_d   = (fin_ok && owner == REQ_D && !mem_we_q) ? mem_rdata : d_rdata_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      bus_err_q   <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      mem_valid_q <= mem_valid_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_done_q    <= i_done_d;
      d_done_q    <= d_done_d;
      bus_err_q   <= bus_err_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end
  assign mem_valid = mem_valid_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_done    = i_done_q;
  assign d_done    = d_done_q;
  assign bus_err   = bus_err_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, streak limit, timeout and reset behaviour
module tb_mem_port_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ready = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic i_done, d_done, bus_err, mem_valid, mem_we;
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
    .d_done(d_done), .bus_err(bus_err), .mem_valid(mem_valid), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    step();
    step();
    chk("rst_valid", mem_valid, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_idone", i_done, 0);
    chk("rst_ddone", d_done, 0);
    chk("rst_irdata", i_rdata, 0);
    chk("rst_drdata", d_rdata, 0);
    chk("rst_buserr", bus_err, 0);
    // fetch only, minimum latency
    rst = 1'b0; i_req = 1'b1; i_addr = 32'h10; mem_ready = 1'b1; mem_rdata = 32'h0050_0093;
    step();
    chk("f_valid", mem_valid, 1);
    chk("f_addr", mem_addr, 32'h10);
    chk("f_we", mem_we, 0);
    chk("f_nodone", i_done, 0);
    step();
    chk("f_done", i_done, 1);
    chk("f_rdata", i_rdata, 32'h0050_0093);
    chk("f_buserr", bus_err, 0);
    chk("f_valid_off", mem_valid, 0);
    i_req = 1'b0;
    step();
    chk("f_done_pulse", i_done, 0);
    chk("f_no_regrant", mem_valid, 0);
    // simultaneous store and fetch: data first, fetch granted in the d_done cycle
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF;
    i_req = 1'b1; i_addr = 32'h20; mem_rdata = 32'h1111_1111;
    step();
    chk("s_valid", mem_valid, 1);
    chk("s_we", mem_we, 1);
    chk("s_addr", mem_addr, 32'h40);
    chk("s_wdata", mem_wdata, 32'hDEAD_BEEF);
    step();
    chk("s_ddone", d_done, 1);
    chk("s_drdata", d_rdata, 0);
    d_req = 1'b0;
    step();
    chk("s_igrant_valid", mem_valid, 1);
    chk("s_igrant_addr", mem_addr, 32'h20);
    chk("s_igrant_we", mem_we, 0);
    chk("s_igrant_wdata", mem_wdata, 0);
    chk("s_ddone_pulse", d_done, 0);
    step();
    chk("s_idone", i_done, 1);
    chk("s_irdata", i_rdata, 32'h1111_1111);
    i_req = 1'b0;
    step();
    // streak: four data grants while fetch waits, then fetch, then data again
    for (int k = 0; k < 4; k++) begin
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100 + k; i_req = 1'b1; i_addr = 32'h30;
      mem_rdata = 32'hA000 + k;
      step();
      chk("k_dgrant_addr", mem_addr, 32'h100 + k);
      chk("k_dgrant_we", mem_we, 0);
      step();
      chk("k_ddone", d_done, 1);
      chk("k_drdata", d_rdata, 32'hA000 + k);
      i_req = 1'b0;
      step();
      chk("k_idle", mem_valid, 0);
      i_req = 1'b1;
    end
    mem_rdata = 32'h0BAD_F00D;
    step();
    chk("k_igrant_addr", mem_addr, 32'h30);
    chk("k_igrant_we", mem_we, 0);
    step();
    chk("k_idone", i_done, 1);
    chk("k_irdata", i_rdata, 32'h0BAD_F00D);
    d_addr = 32'h104; mem_rdata = 32'h5555_0001;
    step();
    chk("k_d5_addr", mem_addr, 32'h104);
    chk("k_d5_valid", mem_valid, 1);
    step();
    chk("k_d5_done", d_done, 1);
    chk("k_d5_rdata", d_rdata, 32'h5555_0001);
    d_req = 1'b0; i_req = 1'b0;
    step();
    // timeout: done and bus_err 9 cycles after mem_valid rises
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; mem_ready = 1'b0; mem_rdata = 32'hFFFF_0000;
    step();
    chk("t_valid", mem_valid, 1);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("t_wait_valid", mem_valid, 1);
      chk("t_wait_nodone", d_done, 0);
    end
    step();
    chk("t_done", d_done, 1);
    chk("t_buserr", bus_err, 1);
    chk("t_rdata_kept", d_rdata, 32'h5555_0001);
    chk("t_valid_off", mem_valid, 0);
    d_req = 1'b0; i_req = 1'b1; i_addr = 32'h44; mem_ready = 1'b1; mem_rdata = 32'h4444_0044;
    step();
    chk("t_next_addr", mem_addr, 32'h44);
    chk("t_next_valid", mem_valid, 1);
    chk("t_buserr_pulse", bus_err, 0);
    step();
    chk("t_next_done", i_done, 1);
    chk("t_next_buserr", bus_err, 0);
    chk("t_next_rdata", i_rdata, 32'h4444_0044);
    i_req = 1'b0;
    step();
    // mem_ready on the timeout cycle wins
    d_req = 1'b1; d_addr = 32'h210; mem_ready = 1'b0; mem_rdata = 32'h7777_0007;
    step();
    for (int k = 0; k < 8; k++) step();
    chk("r_still_busy", mem_valid, 1);
    mem_ready = 1'b1;
    step();
    chk("r_done", d_done, 1);
    chk("r_buserr", bus_err, 0);
    chk("r_rdata", d_rdata, 32'h7777_0007);
    d_req = 1'b0;
    step();
    // reset during D_BUSY with mem_ready in the same cycle
    d_req = 1'b1; d_addr = 32'h300; mem_ready = 1'b0;
    step();
    chk("x_busy", mem_valid, 1);
    rst = 1'b1; mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D;
    step();
    chk("x_valid", mem_valid, 0);
    chk("x_ddone", d_done, 0);
    chk("x_drdata", d_rdata, 0);
    chk("x_buserr", bus_err, 0);
    rst = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
    step();
    chk("x_stay_idle", mem_valid, 0);
    // delayed mem_ready: outputs stable for four busy cycles, one-cycle done
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500; mem_rdata = 32'h0000_5A5A;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("w_valid", mem_valid, 1);
      chk("w_addr", mem_addr, 32'h500);
      chk("w_we", mem_we, 0);
      chk("w_nodone", d_done, 0);
      if (k == 3) mem_ready = 1'b1;
    end
    step();
    chk("w_done", d_done, 1);
    chk("w_rdata", d_rdata, 32'h0000_5A5A);
    d_req = 1'b0; mem_ready = 1'b0;
    step();
    chk("w_done_width", d_done, 0);
    chk("w_idle", mem_valid, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
